ripple_carry_adder: RTL and testbench



---
 rtl/ripple_carry_adder_pkg.sv | 9 +
 rtl/ripple_carry_adder_full_adder.sv | 16 +
 rtl/ripple_carry_adder.sv | 49 ++++
 tb/tb_ripple_carry_adder.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_pkg.sv
// Shared helpers for the ripple-carry adder slice.
package ripple_carry_adder_pkg;

    // A WIDTH-bit add with carry-in produces WIDTH+1 result bits.
    function automatic int unsigned rca_result_width(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// Single-bit full adder, purely combinational.
module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Parameterized ripple-carry adder built from a full-adder chain,
// with a registered sum/c_out/out_valid stage.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             out_valid
);

    logic [rca_result_width(WIDTH)-1:0] carry;
    logic [WIDTH-1:0]                   s_core;

    assign carry[0] = c_in;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        rca_full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (s_core[i]),
            .cout (carry[i+1])
        );
    end

    // Result registers only load on valid input; out_valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= '0;
            c_out     <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= s_core;
            c_out     <= carry[WIDTH];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH = 4) against an arithmetic model.
module tb_ripple_carry_adder;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic [W-1:0] sum;
    logic         c_out;
    logic         out_valid;

    int checks   = 0;
    int failures = 0;

    logic [W:0] exp_res;
    logic       exp_valid;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sum       (sum),
        .c_out     (c_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".sum"},       32'(sum),       32'(exp_res[W-1:0]));
        check({tag, ".c_out"},     32'(c_out),     32'(exp_res[W]));
        check({tag, ".out_valid"}, 32'(out_valid), 32'(exp_valid));
    endtask

    // Drive one cycle of operands and compare results one edge later.
    task automatic step(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic tv);
        @(negedge clk);
        a        = ta;
        b        = tb;
        c_in     = tc;
        in_valid = tv;
        if (tv) exp_res = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        exp_valid = tv;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        c_in      = 1'b0;
        exp_res   = '0;
        exp_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset_hold");
        @(negedge clk);
        rst_n = 1'b1;

        step("preload", 4'd15, 4'd15, 1'b1, 1'b1);
        check_outputs("preload_nonzero");

        // Asynchronous reset mid-cycle must clear outputs without a clock edge.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_res   = '0;
        exp_valid = 1'b0;
        check_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        step("post_reset", 4'd0,  4'd0, 1'b1, 1'b1);
        step("add_1_1",    4'd1,  4'd1, 1'b0, 1'b1);
        step("add_1_0",    4'd1,  4'd0, 1'b0, 1'b1);
        step("msb_cin",    4'd8,  4'd0, 1'b1, 1'b1);
        step("all_ones",   4'd15, 4'd0, 1'b0, 1'b1);
        step("wrap_15_1",  4'd15, 4'd1, 1'b0, 1'b1);
        step("wrap_15_2c", 4'd15, 4'd2, 1'b1, 1'b1);

        step("hold_a",   4'd3, 4'd4, 1'b0, 1'b0);
        step("hold_b",   4'd5, 4'd6, 1'b1, 1'b0);
        step("resume",   4'd7, 4'd7, 1'b0, 1'b1);

        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = i[8:0];
            step("exhaustive", v[3:0], v[7:4], v[8], 1'b1);
        end

        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            logic         rv;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            rv = ($urandom_range(3, 0) != 0);
            step("random", ra, rb, rc, rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
